// File: rtl/gamma_cycle_sequencer.sv
// gamma_cycle_sequencer
// Runs one race-logic temporal operator through one gamma cycle per request.
// A request carries two spike times; the operator is held in gamma reset for
// one cycle, then its a/b inputs are driven as PULSE_WIDTH-cycle pulses during
// a RUN window of GAMMA_CYCLE_WIDTH cycles. The first rising edge of the
// operator output is time-stamped and returned over a valid/ready interface.
//
// Ports:
//   aclk, grst_n         clock, synchronous active-low reset
//   req_valid/req_ready  request handshake; req_ta/req_tb spike times (>= G: no spike)
//   op_rst, op_a, op_b   registered drives to the operator (gamma reset, pulses)
//   op_q                 operator output, sampled every RUN cycle
//   res_valid/res_ready  result handshake; res_t edge time (G if none), res_spike
//   busy                 sequencer is not idle
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  localparam int TW = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
  input  logic          aclk,
  input  logic          grst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [TW-1:0] req_ta,
  input  logic [TW-1:0] req_tb,
  output logic          op_rst,
  output logic          op_a,
  output logic          op_b,
  input  logic          op_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [TW-1:0] res_t,
  output logic          res_spike,
  output logic          busy
);

  localparam logic [TW-1:0] G_LAST = TW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [TW-1:0] G_NONE = TW'(GAMMA_CYCLE_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] k_q, k_d;
  logic [TW-1:0] ta_q, tb_q;
  logic          q_prev;
  logic          op_rst_d, op_a_d, op_b_d;

  // Pulse window test done in 32 bits so t+PW cannot overflow TW bits.
  // k is always < G inside RUN, so truncation at G-1 falls out naturally.
  function automatic logic in_pulse(input logic [TW-1:0] t, input logic [TW-1:0] k);
    logic [31:0] t32;
    logic [31:0] k32;
    t32 = 32'(t);
    k32 = 32'(k);
    return (k32 >= t32) && (k32 < t32 + 32'(PULSE_WIDTH));
  endfunction

  // State and run counter register
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state and next run index
  always_comb begin
    state_d = state_q;
    k_d     = '0;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_RESET;
      S_RESET: state_d = S_RUN;
      S_RUN: begin
        if (k_q == G_LAST) state_d = S_DONE;
        else               k_d     = k_q + 1'b1;
      end
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; operator drives are decoded from the next state/index so that
  // the registered copies line up exactly with the RUN cycle they belong to.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    res_valid = (state_q == S_DONE);
    op_rst_d  = (state_d != S_RUN);
    op_a_d    = (state_d == S_RUN) && in_pulse(ta_q, k_d);
    op_b_d    = (state_d == S_RUN) && in_pulse(tb_q, k_d);
  end

  // Registered, glitch-free operator drives
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      op_rst <= 1'b1;
      op_a   <= 1'b0;
      op_b   <= 1'b0;
    end else begin
      op_rst <= op_rst_d;
      op_a   <= op_a_d;
      op_b   <= op_b_d;
    end
  end

  // Spike times are captured on acceptance and held until the next IDLE
  always_ff @(posedge aclk) begin
    if (req_ready && req_valid) begin
      ta_q <= req_ta;
      tb_q <= req_tb;
    end
  end

  // Edge capture; res_spike doubles as the "first edge already seen" flag
  always_ff @(posedge aclk) begin
    if (!grst_n) begin
      q_prev    <= 1'b0;
      res_t     <= '0;
      res_spike <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          q_prev    <= 1'b0;
          res_t     <= '0;
          res_spike <= 1'b0;
        end
        S_RUN: begin
          q_prev <= op_q;
          if (!res_spike && op_q && !q_prev) begin
            res_t     <= k_q;
            res_spike <= 1'b1;
          end else if (!res_spike && (k_q == G_LAST)) begin
            res_t <= G_NONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
module tb_gamma_cycle_sequencer;

  localparam int G  = 16;
  localparam int PW = 8;
  localparam int TW = $clog2(G + 1);

  typedef struct packed {
    logic [TW-1:0] t;
    logic          spike;
  } exp_t;

  logic          aclk = 1'b0;
  logic          grst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TW-1:0] req_ta = '0;
  logic [TW-1:0] req_tb = '0;
  logic          op_rst, op_a, op_b, op_q;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [TW-1:0] res_t;
  logic          res_spike;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t exp_q[$];

  gamma_cycle_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
    .aclk(aclk), .grst_n(grst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ta(req_ta), .req_tb(req_tb),
    .op_rst(op_rst), .op_a(op_a), .op_b(op_b), .op_q(op_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_t(res_t), .res_spike(res_spike), .busy(busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Less-than-or-equal race cell: fires when a arrives and b has not yet arrived.
  logic sa = 1'b0, sb = 1'b0;
  always @(posedge aclk) begin
    if (op_rst) begin
      sa <= 1'b0;
      sb <= 1'b0;
    end else begin
      if (op_a) sa <= 1'b1;
      if (op_b) sb <= 1'b1;
    end
  end
  assign op_q = (op_a | sa) & ~sb;

  // Records the op_a/op_b pattern of the most recent RUN window
  int rk = 0;
  int run_len = 0;
  logic [G-1:0] a_vec = '0;
  logic [G-1:0] b_vec = '0;
  always @(negedge aclk) begin
    if (op_rst === 1'b0) begin
      if (rk == 0) begin
        a_vec = '0;
        b_vec = '0;
      end
      if (rk < G) begin
        a_vec[rk] = op_a;
        b_vec[rk] = op_b;
      end
      rk++;
      run_len = rk;
    end else begin
      rk = 0;
    end
  end

  function automatic logic [G-1:0] pulse_vec(input int t);
    logic [G-1:0] v;
    for (int k = 0; k < G; k++) v[k] = (k >= t) && (k < t + PW);
    return v;
  endfunction

  function automatic exp_t model(input int ta, input int tb);
    exp_t e;
    e.spike = (ta < G) && (ta <= tb);
    e.t     = e.spike ? TW'(ta) : TW'(G);
    return e;
  endfunction

  task automatic send(input int ta, input int tb, output int acc);
    acc = -1;
    req_ta = TW'(ta);
    req_tb = TW'(tb);
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (req_ready) begin
        @(posedge aclk);
        #1;
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc >= 0) exp_q.push_back(model(ta, tb));
  endtask

  task automatic wait_valid(output int vc);
    vc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (res_valid) begin
        vc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    grst_n = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({op_rst, op_a, op_b} !== 3'b100) begin
      failures++;
      $display("FAIL reset_op_drives got=%b expected=100", {op_rst, op_a, op_b});
    end
    checks++;
    if ({res_valid, res_spike, res_t} !== '0) begin
      failures++;
      $display("FAIL reset_result got valid=%b spike=%b t=%0d expected 0/0/0", res_valid, res_spike, res_t);
    end
    checks++;
    if ({busy, req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_idle got busy=%b req_ready=%b expected 0/1", busy, req_ready);
    end
    @(posedge aclk);
    #1;
    grst_n = 1'b1;
  endtask

  task automatic test_basic();
    int acc, vc;
    exp_t e;
    send(3, 7, acc);
    req_ta = 5'd9;
    req_tb = 5'd1;
    wait_valid(vc);
    checks++;
    if (acc < 0 || vc != acc + G + 1) begin
      failures++;
      $display("FAIL basic_latency got accept=%0d valid=%0d expected valid=accept+%0d", acc, vc, G + 1);
    end
    e = exp_q.pop_front();
    checks++;
    if (res_t !== e.t || res_spike !== e.spike || res_t !== 5'd3) begin
      failures++;
      $display("FAIL basic_result got t=%0d spike=%b expected t=%0d spike=%b", res_t, res_spike, e.t, e.spike);
    end
    checks++;
    if (a_vec !== pulse_vec(3) || b_vec !== pulse_vec(7) || run_len != G) begin
      failures++;
      $display("FAIL basic_pulses got a=%b b=%b len=%0d expected a=%b b=%b len=%0d",
               a_vec, b_vec, run_len, pulse_vec(3), pulse_vec(7), G);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_inverted();
    int acc, vc, bad;
    exp_t e;
    send(9, 2, acc);
    @(negedge aclk);
    checks++;
    if (op_rst !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL inv_reset_phase got op_rst=%b busy=%b expected 1/1", op_rst, busy);
    end
    bad = 0;
    repeat (G) begin
      @(negedge aclk);
      if (op_rst !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL inv_run_op_rst got %0d cycles with op_rst!=0 expected 0", bad);
    end
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc < 0 || res_t !== e.t || res_spike !== e.spike || op_rst !== 1'b1) begin
      failures++;
      $display("FAIL inv_result got t=%0d spike=%b op_rst=%b expected t=%0d spike=%b op_rst=1",
               res_t, res_spike, op_rst, e.t, e.spike);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_no_spike_truncated();
    int acc, vc;
    exp_t e;
    send(20, 5, acc);
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc < 0 || res_t !== e.t || res_spike !== 1'b0) begin
      failures++;
      $display("FAIL nospike_result got t=%0d spike=%b expected t=%0d spike=0", res_t, res_spike, e.t);
    end
    checks++;
    if (a_vec !== '0 || b_vec !== pulse_vec(5)) begin
      failures++;
      $display("FAIL nospike_pulses got a=%b b=%b expected a=0 b=%b", a_vec, b_vec, pulse_vec(5));
    end
    @(posedge aclk);
    #1;
    send(12, 12, acc);
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc < 0 || res_t !== e.t || res_spike !== e.spike || res_t !== 5'd12) begin
      failures++;
      $display("FAIL trunc_result got t=%0d spike=%b expected t=%0d spike=%b", res_t, res_spike, e.t, e.spike);
    end
    checks++;
    if (a_vec !== 16'hF000 || b_vec !== 16'hF000 || run_len != G) begin
      failures++;
      $display("FAIL trunc_pulses got a=%b b=%b len=%0d expected a=b=%b", a_vec, b_vec, run_len, 16'hF000);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_backpressure();
    int acc, vc, bad, rel;
    exp_t e;
    res_ready = 1'b0;
    send(4, 10, acc);
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc < 0 || res_t !== e.t || res_spike !== e.spike) begin
      failures++;
      $display("FAIL bp_result got t=%0d spike=%b expected t=%0d spike=%b", res_t, res_spike, e.t, e.spike);
    end
    req_ta = 5'd1;
    req_tb = 5'd2;
    req_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge aclk);
      if (res_valid !== 1'b1 || res_t !== e.t || res_spike !== e.spike || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles expected 0", bad);
    end
    @(posedge aclk);
    #1;
    rel = cyc;
    res_ready = 1'b1;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (req_ready) begin
        @(posedge aclk);
        #1;
        acc = cyc;
        break;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (acc != rel + 2) begin
      failures++;
      $display("FAIL bp_accept got accept=%0d expected %0d", acc, rel + 2);
    end
    if (acc >= 0) exp_q.push_back(model(1, 2));
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc < 0 || res_t !== e.t || res_spike !== e.spike) begin
      failures++;
      $display("FAIL bp_next_result got t=%0d spike=%b expected t=%0d spike=%b", res_t, res_spike, e.t, e.spike);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int acc, vc;
    exp_t e;
    send(2, 6, acc);
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (op_a !== 1'b1 || op_rst !== 1'b0) begin
      failures++;
      $display("FAIL midrst_k5 got op_a=%b op_rst=%b expected 1/0", op_a, op_rst);
    end
    grst_n = 1'b0;
    @(posedge aclk);
    #1;
    checks++;
    if ({op_a, op_b, op_rst, res_valid, req_ready, busy} !== 6'b001010) begin
      failures++;
      $display("FAIL midrst_state got a/b/rst/valid/ready/busy=%b expected 001010",
               {op_a, op_b, op_rst, res_valid, req_ready, busy});
    end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    grst_n = 1'b1;
    send(5, 5, acc);
    wait_valid(vc);
    e = exp_q.pop_front();
    checks++;
    if (vc != acc + G + 1 || res_t !== e.t || res_spike !== e.spike || a_vec !== pulse_vec(5)) begin
      failures++;
      $display("FAIL midrst_after got t=%0d spike=%b a=%b valid_at=%0d expected t=%0d spike=%b a=%b valid_at=%0d",
               res_t, res_spike, a_vec, vc, e.t, e.spike, pulse_vec(5), acc + G + 1);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_back_to_back();
    int tas[3] = '{1, 6, 0};
    int tbs[3] = '{4, 2, 0};
    int acc[3] = '{0, 0, 0};
    int na = 0;
    int nr = 0;
    logic take;
    exp_t e;
    res_ready = 1'b1;
    req_ta = TW'(tas[0]);
    req_tb = TW'(tbs[0]);
    req_valid = 1'b1;
    for (int i = 0; i < 300 && nr < 3; i++) begin
      @(negedge aclk);
      if (res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_result got t=%0d with no outstanding request", res_t);
        end else begin
          e = exp_q.pop_front();
          if (res_t !== e.t || res_spike !== e.spike) begin
            failures++;
            $display("FAIL b2b_result[%0d] got t=%0d spike=%b expected t=%0d spike=%b",
                     nr, res_t, res_spike, e.t, e.spike);
          end
        end
        nr++;
      end
      take = req_valid && req_ready;
      @(posedge aclk);
      #1;
      if (take) begin
        acc[na] = cyc;
        exp_q.push_back(model(tas[na], tbs[na]));
        na++;
        if (na < 3) begin
          req_ta = TW'(tas[na]);
          req_tb = TW'(tbs[na]);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nr != 3 || na != 3) begin
      failures++;
      $display("FAIL b2b_count got accepted=%0d results=%0d expected 3/3", na, nr);
    end
    checks++;
    if (acc[1] - acc[0] != G + 3 || acc[2] - acc[1] != G + 3) begin
      failures++;
      $display("FAIL b2b_period got %0d,%0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], G + 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverted();
    test_no_spike_truncated();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
